// File: rtl/hyperbus_burst_fifo_pkg.sv
// Shared types and helpers for the Hyperbus burst adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hyperbus_burst_fifo_pkg;

   // One-hot controller states.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_WRITE = 4'b0010,
      ST_READ  = 4'b0100,
      ST_WAIT  = 4'b1000
   } state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // Number of Hyperbus beats that make up one user word.
   function automatic int beats_per_word(input int fifo_w, input int hbus_w);
      return fifo_w / hbus_w;
   endfunction

   // Command FIFO entry is packed as {we, len, adr}.
   function automatic int cmd_entry_width(input int addr_w, input int len_w);
      return 1 + len_w + addr_w;
   endfunction

endpackage

// File: rtl/hyperbus_burst_fifo_if.sv
// Bundle of the user command/data handshakes and the Hyperbus native signals.
// Latency: n/a (wires only).
// Backpressure: cmd/tx/rx valid-ready; Hyperbus side uses hbus_ready/hbus_valid/hbus_busy.
// Ports: master = user logic plus Hyperbus controller side, slave = the burst adapter.
interface hyperbus_burst_fifo_if #(
   parameter int FIFO_DATA_WIDTH = 32,
   parameter int HBUS_DATA_WIDTH = 16,
   parameter int HBUS_ADDR_WIDTH = 32,
   parameter int MAX_BURST_LOG2  = 4
);
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic                       cmd_we;
   logic [HBUS_ADDR_WIDTH-1:0] cmd_adr;
   logic [MAX_BURST_LOG2-1:0]  cmd_len;

   logic                       tx_valid;
   logic                       tx_ready;
   logic [FIFO_DATA_WIDTH-1:0] tx_dat;

   logic                       rx_valid;
   logic                       rx_ready;
   logic [FIFO_DATA_WIDTH-1:0] rx_dat;

   logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o;
   logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
   logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
   logic                       hbus_rrq;
   logic                       hbus_wrq;
   logic                       hbus_ready;
   logic                       hbus_valid;
   logic                       hbus_busy;

   modport master (
      output cmd_valid, cmd_we, cmd_adr, cmd_len, tx_valid, tx_dat, rx_ready,
             hbus_dat_i, hbus_ready, hbus_valid, hbus_busy,
      input  cmd_ready, tx_ready, rx_valid, rx_dat,
             hbus_adr_o, hbus_dat_o, hbus_rrq, hbus_wrq
   );

   modport slave (
      input  cmd_valid, cmd_we, cmd_adr, cmd_len, tx_valid, tx_dat, rx_ready,
             hbus_dat_i, hbus_ready, hbus_valid, hbus_busy,
      output cmd_ready, tx_ready, rx_valid, rx_dat,
             hbus_adr_o, hbus_dat_o, hbus_rrq, hbus_wrq
   );
endinterface

// File: rtl/hyperbus_burst_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy level output.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller derives ready/valid from level.
// Ports: clk/rst, push/push_dat, pop, head (current front word), level (0..2^DEPTH_LOG2).
module hyperbus_burst_fifo_sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_dat,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic [DEPTH_LOG2:0]   level
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  full;
   logic                  empty;
   logic                  do_push;
   logic                  do_pop;

   // Level never exceeds DEPTH, so its top bit alone means full.
   assign full    = level[DEPTH_LOG2];
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/hyperbus_burst_fifo.sv
// Burst adapter: queues user read/write commands and data, serialises words into Hyperbus beats.
// Latency: command accepted at edge N raises the request after edge N+1; read word visible after its last beat edge.
// Backpressure: cmd/tx ready = FIFO not full, rx valid = FIFO not empty; bursts start only when all data/space is present.
// Ports: clk, rst (sync, active-high), bus (slave modport carrying user handshakes and Hyperbus signals).
module hyperbus_burst_fifo
   import hyperbus_burst_fifo_pkg::*;
#(
   parameter int FIFO_DATA_WIDTH = 32,
   parameter int HBUS_DATA_WIDTH = 16,
   parameter int HBUS_ADDR_WIDTH = 32,
   parameter int DEPTH_LOG2      = 2,
   parameter int MAX_BURST_LOG2  = 4,
   parameter int MSB_FIRST       = 1
) (
   input  logic                clk,
   input  logic                rst,
   hyperbus_burst_fifo_if.slave bus
);
   localparam int BEATS  = beats_per_word(FIFO_DATA_WIDTH, HBUS_DATA_WIDTH);
   localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CMD_W  = cmd_entry_width(HBUS_ADDR_WIDTH, MAX_BURST_LOG2);
   localparam int LVL_W  = DEPTH_LOG2 + 1;
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   if ((FIFO_DATA_WIDTH % HBUS_DATA_WIDTH) != 0 || FIFO_DATA_WIDTH < HBUS_DATA_WIDTH) begin : g_bad_width
      $error("FIFO_DATA_WIDTH must be a positive multiple of HBUS_DATA_WIDTH");
   end
   if (DEPTH_LOG2 < 1 || MAX_BURST_LOG2 < 1) begin : g_bad_depth
      $error("DEPTH_LOG2 and MAX_BURST_LOG2 must be at least 1");
   end

   // A command with len+1 greater than the FIFO depth can never meet the
   // start condition and stalls the queue; callers keep bursts within depth.

   state_t                      state;
   logic                        ready_en;
   logic [HBUS_ADDR_WIDTH-1:0]  adr_q;
   logic                        wrq_q;
   logic                        rrq_q;
   logic [MAX_BURST_LOG2-1:0]   word_cnt;
   logic [BW-1:0]               beat_cnt;
   logic [FIFO_DATA_WIDTH-1:0]  asm_q;
   logic [FIFO_DATA_WIDTH-1:0]  asm_next;
   logic [FIFO_DATA_WIDTH-1:0]  dat_i_ext;

   logic [CMD_W-1:0]            cmd_head;
   logic [LVL_W-1:0]            cmd_level;
   logic [FIFO_DATA_WIDTH-1:0]  tx_head;
   logic [LVL_W-1:0]            tx_level;
   logic [LVL_W-1:0]            rx_level;

   logic                        head_we;
   logic [MAX_BURST_LOG2-1:0]   head_len;
   logic [HBUS_ADDR_WIDTH-1:0]  head_adr;
   logic [31:0]                 need;
   logic [31:0]                 rx_free;
   logic                        start;
   logic                        tx_pop;
   logic                        rx_push;
   logic [BW-1:0]               slice_idx;

   assign {head_we, head_len, head_adr} = cmd_head;

   // ready_en holds user ready low through reset and rises one cycle after it.
   assign bus.cmd_ready = ready_en && (cmd_level != LVL_W'(DEPTH));
   assign bus.tx_ready  = ready_en && (tx_level != LVL_W'(DEPTH));
   assign bus.rx_valid  = (rx_level != '0);

   assign need    = 32'(head_len) + 32'd1;
   assign rx_free = 32'(DEPTH) - 32'(rx_level);
   assign start   = (state == ST_IDLE) && (cmd_level != '0) && !bus.hbus_busy &&
                    ((head_we == CMD_WRITE) ? (32'(tx_level) >= need) : (rx_free >= need));

   assign tx_pop  = (state == ST_WRITE) && bus.hbus_ready && (beat_cnt == '0);
   assign rx_push = (state == ST_READ)  && bus.hbus_valid && (beat_cnt == '0);

   // beat_cnt counts down, so MSB-first emits the top slice first.
   assign slice_idx      = (MSB_FIRST != 0) ? beat_cnt : (LAST_BEAT - beat_cnt);
   assign bus.hbus_dat_o = (state == ST_WRITE) ?
                           HBUS_DATA_WIDTH'(tx_head >> (HBUS_DATA_WIDTH * int'(slice_idx))) : '0;

   // After BEATS shifts every stale bit of asm_q has been pushed out, so no clear between words.
   assign dat_i_ext = FIFO_DATA_WIDTH'(bus.hbus_dat_i);
   assign asm_next  = (MSB_FIRST != 0) ?
                      ((asm_q << HBUS_DATA_WIDTH) | dat_i_ext) :
                      ((asm_q >> HBUS_DATA_WIDTH) | (dat_i_ext << (FIFO_DATA_WIDTH - HBUS_DATA_WIDTH)));

   assign bus.hbus_adr_o = adr_q;
   assign bus.hbus_wrq   = wrq_q;
   assign bus.hbus_rrq   = rrq_q;

   hyperbus_burst_fifo_sync_fifo #(.WIDTH(CMD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_cmd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (bus.cmd_valid && bus.cmd_ready),
      .push_dat ({bus.cmd_we, bus.cmd_len, bus.cmd_adr}),
      .pop      (start),
      .head     (cmd_head),
      .level    (cmd_level)
   );

   hyperbus_burst_fifo_sync_fifo #(.WIDTH(FIFO_DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (bus.tx_valid && bus.tx_ready),
      .push_dat (bus.tx_dat),
      .pop      (tx_pop),
      .head     (tx_head),
      .level    (tx_level)
   );

   hyperbus_burst_fifo_sync_fifo #(.WIDTH(FIFO_DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rx_push),
      .push_dat (asm_next),
      .pop      (bus.rx_ready && bus.rx_valid),
      .head     (bus.rx_dat),
      .level    (rx_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ready_en <= 1'b0;
         adr_q    <= '0;
         wrq_q    <= 1'b0;
         rrq_q    <= 1'b0;
         word_cnt <= '0;
         beat_cnt <= '0;
         asm_q    <= '0;
      end else begin
         ready_en <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  adr_q    <= head_adr;
                  word_cnt <= head_len;
                  beat_cnt <= LAST_BEAT;
                  if (head_we == CMD_WRITE) begin
                     wrq_q <= 1'b1;
                     state <= ST_WRITE;
                  end else begin
                     rrq_q <= 1'b1;
                     state <= ST_READ;
                  end
               end
            end
            ST_WRITE: begin
               if (bus.hbus_ready) begin
                  if (beat_cnt == '0) begin
                     if (word_cnt == '0) begin
                        wrq_q <= 1'b0;
                        state <= ST_WAIT;
                     end else begin
                        word_cnt <= word_cnt - 1'b1;
                        beat_cnt <= LAST_BEAT;
                     end
                  end else begin
                     beat_cnt <= beat_cnt - 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (bus.hbus_valid) begin
                  asm_q <= asm_next;
                  if (beat_cnt == '0) begin
                     if (word_cnt == '0) begin
                        rrq_q <= 1'b0;
                        state <= ST_WAIT;
                     end else begin
                        word_cnt <= word_cnt - 1'b1;
                        beat_cnt <= LAST_BEAT;
                     end
                  end else begin
                     beat_cnt <= beat_cnt - 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (!bus.hbus_busy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
